// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: row drive, raw column inputs and the debounced key event.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0] row_out;
  logic [3:0] col_in;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    output row_out,
    output key_code,
    output key_valid,
    output key_held,
    input  col_in
  );

  modport slave (
    input  row_out,
    input  key_code,
    input  key_valid,
    input  key_held,
    output col_in
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with synchronizer, press/release debounce and one-cycle key strobe.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV     = 48000,
  parameter int DEBOUNCE_CNT = 480000,
  parameter int REPEAT_DELAY = 24000000,
  parameter int REPEAT_RATE  = 4800000
) (
  input  logic              clk,
  input  logic              reset_in,
  keypad_scanner_if.master  bus
);

  localparam int MAX_A = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int MAX_B = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = (MAX_P > 2) ? $clog2(MAX_P) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_FIRST_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
`endif

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       row_idx_reg, row_idx_next;
  logic [1:0]       col_idx_reg, col_idx_next;
  logic [CNT_W-1:0] dwell_reg, dwell_next;
  logic [CNT_W-1:0] deb_reg, deb_next;
  logic [3:0]       code_reg, code_next;
  logic             valid_reg, valid_next;
  logic [3:0]       col_meta_reg;
  logic [3:0]       col_s_reg;
`ifdef KEYPAD_REPEAT_EN
  logic [CNT_W-1:0] rep_reg, rep_next;
  logic             rep_first_reg, rep_first_next;
`endif

  logic [1:0] win_col;
  logic       col_bit;

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Lowest low column wins when several are pressed on the same row.
  always_comb begin
    win_col = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (!col_s_reg[c]) win_col = 2'(c);
    end
  end

  assign col_bit = col_s_reg[col_idx_reg];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      assign bus.row_out[gi] = (row_idx_reg != 2'(gi));
    end
  endgenerate

  assign bus.key_code  = code_reg;
  assign bus.key_valid = valid_reg;
  assign bus.key_held  = (state_reg == HELD);

  always_ff @(posedge clk) begin
    if (reset_in) begin
      col_meta_reg <= 4'hF;
      col_s_reg    <= 4'hF;
    end else begin
      col_meta_reg <= bus.col_in;
      col_s_reg    <= col_meta_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_reg     <= SCAN;
      row_idx_reg   <= 2'd0;
      col_idx_reg   <= 2'd0;
      dwell_reg     <= '0;
      deb_reg       <= '0;
      code_reg      <= 4'h0;
      valid_reg     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_reg       <= '0;
      rep_first_reg <= 1'b1;
`endif
    end else begin
      state_reg     <= state_next;
      row_idx_reg   <= row_idx_next;
      col_idx_reg   <= col_idx_next;
      dwell_reg     <= dwell_next;
      deb_reg       <= deb_next;
      code_reg      <= code_next;
      valid_reg     <= valid_next;
`ifdef KEYPAD_REPEAT_EN
      rep_reg       <= rep_next;
      rep_first_reg <= rep_first_next;
`endif
    end
  end

  // Counters default to zero so each one only runs inside its own state.
  always_comb begin
    state_next   = state_reg;
    row_idx_next = row_idx_reg;
    col_idx_next = col_idx_reg;
    dwell_next   = '0;
    deb_next     = '0;
    code_next    = code_reg;
    valid_next   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_next       = '0;
    rep_first_next = rep_first_reg;
`endif

    case (state_reg)
      SCAN: begin
        if (dwell_reg == DWELL_LAST) begin
          if (col_s_reg == 4'hF) begin
            row_idx_next = row_idx_reg + 2'd1;
          end else begin
            col_idx_next = win_col;
            state_next   = DEBOUNCE;
          end
        end else begin
          dwell_next = dwell_reg + CNT_ONE;
        end
      end

      DEBOUNCE: begin
        if (col_bit) begin
          state_next   = SCAN;
          row_idx_next = row_idx_reg + 2'd1;
        end else if (deb_reg == DEB_LAST) begin
          code_next  = key_lookup(row_idx_reg, col_idx_reg);
          valid_next = 1'b1;
          state_next = HELD;
`ifdef KEYPAD_REPEAT_EN
          rep_first_next = 1'b1;
`endif
        end else begin
          deb_next = deb_reg + CNT_ONE;
        end
      end

      HELD: begin
        if (col_bit) begin
          state_next = RELEASE;
        end else begin
`ifdef KEYPAD_REPEAT_EN
          if (rep_first_reg ? (rep_reg == REP_FIRST_LAST) : (rep_reg == REP_RATE_LAST)) begin
            valid_next     = 1'b1;
            rep_first_next = 1'b0;
          end else begin
            rep_next = rep_reg + CNT_ONE;
          end
`endif
        end
      end

      RELEASE: begin
        if (!col_bit) begin
          // Release bounce: back to HELD without a new event.
          state_next = HELD;
`ifdef KEYPAD_REPEAT_EN
          rep_first_next = 1'b1;
`endif
        end else if (deb_reg == DEB_LAST) begin
          state_next   = SCAN;
          row_idx_next = row_idx_reg + 2'd1;
        end else begin
          deb_next = deb_reg + CNT_ONE;
        end
      end

      default: state_next = SCAN;
    endcase
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans the 4x4 matrix keypad and delivers debounced key events to fsm_module, directly upstream of it. Runs on the 48 MHz SB_HFOSC clock.
- Drives the four row lines gpio_28/gpio_38/gpio_42/gpio_36, active-low one-hot. Reads the four column lines gpio_43/gpio_34/gpio_37/gpio_31, active-low with pull-ups.
- Output is a 4-bit key code plus a one-cycle valid strobe per accepted press.

Parameters:
- SCAN_DIV, 48000: clock cycles each row is driven (dwell time, 1 ms at 48 MHz); minimum 4.
- DEBOUNCE_CNT, 480000: consecutive stable cycles required to accept a press or a release (10 ms); minimum 2.
- REPEAT_DELAY, 24000000: cycles held before the first auto-repeat (used only with KEYPAD_REPEAT_EN).
- REPEAT_RATE, 4800000: cycles between auto-repeats (used only with KEYPAD_REPEAT_EN).

Ports:
- clk, input, 1: system clock.
- reset_in, input, 1: synchronous, active-high reset.
- row_out, output, 4: row drive; one bit low at a time, bit r = row r.
- col_in, input, 4: raw column inputs, asynchronous; bit c = column c; low = pressed.
- key_code, output, 4: code of the last accepted key; stable until the next accepted key.
- key_valid, output, 1: one-cycle strobe; key_code is valid in the same cycle.
- key_held, output, 1: high while the accepted key remains pressed (HELD state).

Behaviour:
- Reset (reset_in sampled high at a clk edge):
  - row_out=4'b1110, key_code=4'h0, key_valid=0, key_held=0.
  - State SCAN, row index 0, all counters 0.
  - The synchronizer flops reset to 4'b1111.
  - Reset mid-debounce or mid-hold aborts with no key_valid.
- Synchronizer: col_in passes through 2 flops to give col_s. All decisions use col_s only.
- Key map: code = table[row][col], lowest column index wins if several columns are low.
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: E(*),0,F(#),D
- SCAN state:
  - The dwell counter counts 0..SCAN_DIV-1 with row_out constant.
  - The sample cycle is the last dwell cycle.
  - If col_s==4'hF at the sample: advance the row index, wrapping 3 to 0, and reset the dwell counter.
  - Otherwise: capture the row index and the winning column, hold row_out, clear the debounce counter, go to DEBOUNCE.
- DEBOUNCE state:
  - Each cycle, if the captured column bit of col_s is low, the debounce counter increments.
  - If that bit is high, go back to SCAN and advance to the next row with no event.
  - When the counter reaches DEBOUNCE_CNT-1 with the bit still low: load key_code, pulse key_valid for the next cycle, go to HELD.
  - Latency: the sample cycle is S; key_valid is high in cycle S+DEBOUNCE_CNT+1.
- HELD state:
  - key_held=1 and row_out is unchanged.
  - When the captured column bit goes high, clear the counter and go to RELEASE.
- RELEASE state:
  - key_held=0.
  - The counter increments while the captured bit is high.
  - If the bit goes low again, return to HELD with no new key_valid (bounce).
  - At DEBOUNCE_CNT-1: go to SCAN at the next row.
- Other keys: presses on other rows or columns are ignored while outside SCAN. There is no rollover.
- Counters: width is $clog2 of the largest parameter. No counter runs free outside its own state.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- When defined, in HELD a repeat counter runs:
  - After REPEAT_DELAY cycles in HELD, key_valid pulses once with the same key_code.
  - After that, key_valid pulses every REPEAT_RATE cycles until leaving HELD.
  - The repeat counter clears on entry to HELD.
- When undefined, the repeat logic is absent and there is exactly one key_valid per press.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_DELAY=40, REPEAT_RATE=16; a model drives col_in from row_out plus the pressed key):
- Reset then no key for 64 cycles -> row_out cycles 1110,1101,1011,0111 every 4 cycles; key_valid never high; key_code=0.
- Press row1/col2 steadily -> exactly one key_valid with key_code=4'h6; key_held=1 until release; after release plus 8 stable cycles, scanning resumes at row2.
- Press row3/col1 with a 3-cycle glitch during DEBOUNCE -> no key_valid from the glitch; the stable press that follows yields key_code=4'h0.
- Row0 col0 and col3 low together -> key_code=4'h1. Release bounce of 2 cycles inside RELEASE -> no second key_valid.
- reset_in asserted 4 cycles into DEBOUNCE -> outputs return to reset values next cycle; no key_valid.
- With KEYPAD_REPEAT_EN, hold '#' for 100 cycles after acceptance -> key_valid with key_code=4'hF at acceptance, then at +40, +56, +72 and +88 cycles; without the macro, only the first pulse.
